// File: rtl/dpram_access_ctrl.sv
// dpram_access_ctrl: initiator side of a dual-port RAM.
// Two valid/ready request channels (A, B) are registered onto the matching RAM
// ports. Reads return the RAM's registered data two cycles after acceptance.
// Same-address hazards where at least one side writes are resolved by a
// toggling priority, so a stalled port always wins the next conflict.
// Optional feature macro: DPRAM_CTRL_COLL_CNT_EN builds the saturating
// conflict counter; without it coll_cnt is tied to zero.
module dpram_access_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              ram_w_a,
  output logic [ADDR_W-1:0] ram_add_a,
  output logic [DATA_W-1:0] ram_d_in_a,
  input  logic [DATA_W-1:0] ram_d_out_a,
  output logic              ram_w_b,
  output logic [ADDR_W-1:0] ram_add_b,
  output logic [DATA_W-1:0] ram_d_in_b,
  input  logic [DATA_W-1:0] ram_d_out_b,
  output logic [7:0]        coll_cnt
);

  typedef enum logic {PRIO_A, PRIO_B} prio_t;

  prio_t prio;
  logic  conflict;
  logic  a_acc;
  logic  b_acc;
  logic  a_rd_pend;
  logic  b_rd_pend;

  // A conflict is a same-address pair where at least one side writes.
  assign conflict = a_req_valid & b_req_valid & (a_req_addr == b_req_addr)
                    & (a_req_we | b_req_we);

  // Only the priority holder may proceed during a conflict; nobody is ready in reset.
  assign a_req_ready = ~rst & (~conflict | (prio == PRIO_A));
  assign b_req_ready = ~rst & (~conflict | (prio == PRIO_B));

  assign a_acc = a_req_valid & a_req_ready;
  assign b_acc = b_req_valid & b_req_ready;

  // The RAM already registers its read data, so the response data is passed straight through.
  assign a_rsp_rdata = ram_d_out_a;
  assign b_rsp_rdata = ram_d_out_b;

  // Channel A issue stage: drive RAM port A for one cycle and track pending reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_w_a     <= 1'b0;
      ram_add_a   <= '0;
      ram_d_in_a  <= '0;
      a_rd_pend   <= 1'b0;
      a_rsp_valid <= 1'b0;
    end else begin
      ram_w_a     <= a_acc & a_req_we;
      a_rd_pend   <= a_acc & ~a_req_we;
      a_rsp_valid <= a_rd_pend;
      if (a_acc) begin
        ram_add_a  <= a_req_addr;
        ram_d_in_a <= a_req_wdata;
      end
    end
  end

  // Channel B issue stage: drive RAM port B for one cycle and track pending reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_w_b     <= 1'b0;
      ram_add_b   <= '0;
      ram_d_in_b  <= '0;
      b_rd_pend   <= 1'b0;
      b_rsp_valid <= 1'b0;
    end else begin
      ram_w_b     <= b_acc & b_req_we;
      b_rd_pend   <= b_acc & ~b_req_we;
      b_rsp_valid <= b_rd_pend;
      if (b_acc) begin
        ram_add_b  <= b_req_addr;
        ram_d_in_b <= b_req_wdata;
      end
    end
  end

  // Priority FSM: every conflict hands priority to the port that just lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PRIO_A;
    end else begin
      case (prio)
        PRIO_A:  if (conflict) prio <= PRIO_B;
        PRIO_B:  if (conflict) prio <= PRIO_A;
        default: prio <= PRIO_A;
      endcase
    end
  end

`ifdef DPRAM_CTRL_COLL_CNT_EN
  logic [7:0] coll_q;

  // Saturating count of arbitrated conflicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_q <= 8'd0;
    end else if (conflict && (coll_q != 8'hFF)) begin
      coll_q <= coll_q + 8'd1;
    end
  end

  assign coll_cnt = coll_q;
`else
  assign coll_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// tb_dpram_access_ctrl: directed scenarios plus randomized traffic for
// dpram_access_ctrl, with a behavioural RAM and a transaction-level model.
// Honours DPRAM_CTRL_COLL_CNT_EN the same way the design does.
module tb_dpram_access_ctrl;

`ifdef DPRAM_CTRL_COLL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [3:0] a_req_addr = '0;
  logic [7:0] a_req_wdata = '0;
  logic       b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [3:0] b_req_addr = '0;
  logic [7:0] b_req_wdata = '0;
  logic       a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [7:0] a_rsp_rdata, b_rsp_rdata;
  logic       ram_w_a, ram_w_b;
  logic [3:0] ram_add_a, ram_add_b;
  logic [7:0] ram_d_in_a, ram_d_in_b;
  logic [7:0] ram_d_out_a = '0, ram_d_out_b = '0;
  logic [7:0] coll_cnt;

  int tests = 0;
  int fails = 0;

  dpram_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .ram_w_a(ram_w_a), .ram_add_a(ram_add_a), .ram_d_in_a(ram_d_in_a), .ram_d_out_a(ram_d_out_a),
    .ram_w_b(ram_w_b), .ram_add_b(ram_add_b), .ram_d_in_b(ram_d_in_b), .ram_d_out_b(ram_d_out_b),
    .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM with registered, read-first outputs; not reset.
  logic [7:0] ram_mem [16];
  initial for (int i = 0; i < 16; i++) ram_mem[i] = 8'h00;

  always @(posedge clk) begin
    if (ram_w_a) ram_mem[ram_add_a] <= ram_d_in_a;
    if (ram_w_b) ram_mem[ram_add_b] <= ram_d_in_b;
    ram_d_out_a <= ram_mem[ram_add_a];
    ram_d_out_b <= ram_mem[ram_add_b];
  end

  // Transaction-level model: shadow memory updated at acceptance, queued expected read data.
  typedef struct {
    int         due;
    logic [7:0] data;
  } rsp_t;

  rsp_t       qa[$];
  rsp_t       qb[$];
  logic [7:0] mem_m [16];
  bit         prio_b = 1'b0;
  int         cnt_m = 0;
  int         ecount = 0;
  bit         exp_w_a = 1'b0, exp_w_b = 1'b0;
  logic [3:0] exp_add_a = '0, exp_add_b = '0;
  logic [7:0] exp_din_a = '0, exp_din_b = '0;

  initial for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;

  function automatic bit model_conflict();
    return a_req_valid && b_req_valid && (a_req_addr == b_req_addr) && (a_req_we || b_req_we);
  endfunction

  function automatic bit model_ready(input bit is_b);
    if (rst) return 1'b0;
    if (!model_conflict()) return 1'b1;
    return (prio_b == is_b);
  endfunction

  // Model update at each edge; reset discards in-flight reads and priority.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      prio_b  = 1'b0;
      cnt_m   = 0;
      exp_w_a = 1'b0;
      exp_w_b = 1'b0;
    end else begin
      bit conf, acc_a, acc_b;
      conf  = model_conflict();
      acc_a = a_req_valid && model_ready(1'b0);
      acc_b = b_req_valid && model_ready(1'b1);
      ecount++;
      if (acc_a && !a_req_we) qa.push_back('{ecount + 1, mem_m[a_req_addr]});
      if (acc_b && !b_req_we) qb.push_back('{ecount + 1, mem_m[b_req_addr]});
      exp_w_a = acc_a && a_req_we;
      exp_w_b = acc_b && b_req_we;
      if (exp_w_a) begin
        exp_add_a = a_req_addr;
        exp_din_a = a_req_wdata;
        mem_m[a_req_addr] = a_req_wdata;
      end
      if (exp_w_b) begin
        exp_add_b = b_req_addr;
        exp_din_b = b_req_wdata;
        mem_m[b_req_addr] = b_req_wdata;
      end
      if (conf) begin
        prio_b = !prio_b;
        if (cnt_m < 255) cnt_m++;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    check_output("a_ready", 32'(a_req_ready), 32'(model_ready(1'b0)));
    check_output("b_ready", 32'(b_req_ready), 32'(model_ready(1'b1)));
    if (qa.size() > 0 && qa[0].due == ecount) begin
      check_output("a_rsp_valid", 32'(a_rsp_valid), 32'd1);
      check_output("a_rsp_rdata", 32'(a_rsp_rdata), 32'(qa[0].data));
      void'(qa.pop_front());
    end else begin
      check_output("a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    end
    if (qb.size() > 0 && qb[0].due == ecount) begin
      check_output("b_rsp_valid", 32'(b_rsp_valid), 32'd1);
      check_output("b_rsp_rdata", 32'(b_rsp_rdata), 32'(qb[0].data));
      void'(qb.pop_front());
    end else begin
      check_output("b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    end
    check_output("ram_w_a", 32'(ram_w_a), 32'(exp_w_a));
    check_output("ram_w_b", 32'(ram_w_b), 32'(exp_w_b));
    if (exp_w_a) begin
      check_output("ram_add_a", 32'(ram_add_a), 32'(exp_add_a));
      check_output("ram_d_in_a", 32'(ram_d_in_a), 32'(exp_din_a));
    end
    if (exp_w_b) begin
      check_output("ram_add_b", 32'(ram_add_b), 32'(exp_add_b));
      check_output("ram_d_in_b", 32'(ram_d_in_b), 32'(exp_din_b));
    end
    check_output("coll_cnt", 32'(coll_cnt), CNT_EN ? 32'(cnt_m) : 32'd0);
  end

  // Drive both channels right after an edge, then wait to the mid-cycle sample point.
  task automatic apply_stimulus(input logic av, input logic awe, input logic [3:0] aaddr, input logic [7:0] ad,
                                input logic bv, input logic bwe, input logic [3:0] baddr, input logic [7:0] bd);
    a_req_valid = av;  a_req_we = awe;  a_req_addr = aaddr;  a_req_wdata = ad;
    b_req_valid = bv;  b_req_we = bwe;  b_req_addr = baddr;  b_req_wdata = bd;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset while a read is in flight: no response, outputs cleared, ready after release.
    apply_stimulus(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    tick();
    rst = 1'b1;
    idle();
    check_output("rst_a_ready", 32'(a_req_ready), 32'd0);
    check_output("rst_ram_add_a", 32'(ram_add_a), 32'd0);
    check_output("rst_a_rsp", 32'(a_rsp_valid), 32'd0);
    tick();
    idle();
    check_output("rst_a_rsp2", 32'(a_rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    check_output("post_rst_a_ready", 32'(a_req_ready), 32'd1);
    check_output("post_rst_b_ready", 32'(b_req_ready), 32'd1);
    tick();

    // Write then read back on A with two-cycle read latency.
    apply_stimulus(1'b1, 1'b1, 4'h3, 8'hA5, 1'b0, 1'b0, 4'h0, 8'h00);
    tick();
    apply_stimulus(1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    check_output("wr_ram_w_a", 32'(ram_w_a), 32'd1);
    tick();
    idle();
    check_output("rd_early_valid", 32'(a_rsp_valid), 32'd0);
    tick();
    idle();
    check_output("rd_a_valid", 32'(a_rsp_valid), 32'd1);
    check_output("rd_a_data", 32'(a_rsp_rdata), 32'hA5);
    tick();

    // Write/write conflict with priority A, then B retries and the value is read back.
    apply_stimulus(1'b1, 1'b1, 4'h5, 8'h11, 1'b1, 1'b1, 4'h5, 8'h22);
    check_output("c1_a_ready", 32'(a_req_ready), 32'd1);
    check_output("c1_b_ready", 32'(b_req_ready), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h5, 8'h22);
    check_output("c1_b_retry", 32'(b_req_ready), 32'd1);
    check_output("c1_coll", 32'(coll_cnt), CNT_EN ? 32'd1 : 32'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    tick();
    idle();
    tick();
    idle();
    check_output("c1_rd_valid", 32'(a_rsp_valid), 32'd1);
    check_output("c1_rd_data", 32'(a_rsp_rdata), 32'h22);
    tick();

    // Same conflict again: B now holds priority.
    apply_stimulus(1'b1, 1'b1, 4'h5, 8'h33, 1'b1, 1'b1, 4'h5, 8'h44);
    check_output("c2_a_ready", 32'(a_req_ready), 32'd0);
    check_output("c2_b_ready", 32'(b_req_ready), 32'd1);
    tick();
    apply_stimulus(1'b1, 1'b1, 4'h5, 8'h33, 1'b0, 1'b0, 4'h0, 8'h00);
    check_output("c2_a_retry", 32'(a_req_ready), 32'd1);
    check_output("c2_coll", 32'(coll_cnt), CNT_EN ? 32'd2 : 32'd0);
    tick();

    // Write/read conflict stalls B once; then different-address writes both proceed.
    apply_stimulus(1'b1, 1'b1, 4'h7, 8'h55, 1'b1, 1'b0, 4'h7, 8'h00);
    check_output("c3_a_ready", 32'(a_req_ready), 32'd1);
    check_output("c3_b_ready", 32'(b_req_ready), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h7, 8'h00);
    check_output("c3_b_retry", 32'(b_req_ready), 32'd1);
    tick();
    apply_stimulus(1'b1, 1'b1, 4'h1, 8'h01, 1'b1, 1'b1, 4'h2, 8'h02);
    check_output("nc_a_ready", 32'(a_req_ready), 32'd1);
    check_output("nc_b_ready", 32'(b_req_ready), 32'd1);
    tick();
    idle();
    check_output("c3_rd_valid", 32'(b_rsp_valid), 32'd1);
    check_output("c3_rd_data", 32'(b_rsp_rdata), 32'h55);
    check_output("nc_coll", 32'(coll_cnt), CNT_EN ? 32'd3 : 32'd0);
    tick();

    // Randomized traffic over a small address window to provoke frequent hazards.
    for (int n = 0; n < 2000; n++) begin
      apply_stimulus(($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom),
                     ($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom));
      tick();
    end

    // Sustained conflicts drive the counter into saturation.
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(1'b1, 1'b1, 4'h0, 8'h5A, 1'b1, 1'b1, 4'h0, 8'hA5);
      tick();
    end
    idle();
    check_output("sat_coll", 32'(coll_cnt), CNT_EN ? 32'd255 : 32'd0);
    tick();
    repeat (4) begin
      idle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
